telem_frame_rx: RTL and testbench
=================================

# telem_frame_rx

Receive-side telemetry deframer for the eBike. Sits directly downstream of `UART_rcv` on the `TX` telemetry line and consumes its `rdy`/`rx_data` byte stream, acknowledging each byte with `clr_rdy`. It synchronises on the `0xAA 0x55` preamble and reassembles the 8-byte frame into 12-bit `batt`, `curr` and `torque` words. It also counts good frames and framing errors, for use by benches and on-board debug.

## Interface
- `TIMEOUT` (default 100000): inter-byte timeout in clk cycles while inside a frame.
- `TO_W` (default 17): width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.

- `clk` (in, 1): system clock. Single clock domain.
- `rst` (in, 1): synchronous, active-high reset.
- `rdy` (in, 1): byte-ready flag from `UART_rcv`.
- `rx_data` (in, 8): received byte from `UART_rcv`.
- `clr_rdy` (out, 1): one-cycle acknowledge to `UART_rcv`.
- `batt` (out, 12): last committed battery reading.
- `curr` (out, 12): last committed current reading.
- `torque` (out, 12): last committed torque reading.
- `frm_vld` (out, 1): one-cycle pulse when a complete frame commits.
- `frm_cnt` (out, 16): good-frame count. Wraps 0xFFFF→0.
- `err_cnt` (out, 8): framing-error count. Saturates at 0xFF.
- `synced` (out, 1): high after a good frame; low after any error or reset.

## Operation
- **Frame format (byte order):** 0xAA, 0x55, {4'h0,BATT[11:8]}, BATT[7:0], {4'h0,CURR[11:8]}, CURR[7:0], {4'h0,TORQUE[11:8]}, TORQUE[7:0].
- **Byte accept:** `acc = rdy & ~clr_rdy`. `clr_rdy` is registered and equals `acc` from the previous cycle. A byte is therefore never accepted twice, even though `rdy` stays high for one cycle after `clr_rdy`.
- **States:** HUNT_AA, HUNT_55, B_HI, B_LO, C_HI, C_LO, T_HI, T_LO. Transitions occur only on `acc`, except for timeout.
- **HUNT_AA:**
  - 0xAA → HUNT_55.
  - Any other byte → stay in HUNT_AA. No error is counted.
- **HUNT_55:**
  - 0x55 → B_HI.
  - 0xAA → stay in HUNT_55.
  - Any other byte → HUNT_AA, and `err_cnt`++.
- **\*_HI states:** store `rx_data[3:0]` in a shadow register.
  - `rx_data[7:4] != 0` → HUNT_AA, and `err_cnt`++.
- **\*_LO states:** store `rx_data` in the shadow low byte, then advance to the next state.
- **T_LO accept (commit):**
  - `batt`, `curr` and `torque` load from the shadow registers on the same edge.
  - `frm_vld` = 1 for exactly one cycle.
  - `frm_cnt`++ and `synced` ← 1.
  - Next state is HUNT_AA.
- **Timeout:**
  - The timeout counter clears on every `acc` and when in HUNT_AA. Otherwise it increments each cycle.
  - When it reaches `TIMEOUT`: go to HUNT_AA, `err_cnt`++, discard the shadow registers, `synced` ← 0.
  - If `acc` and counter == `TIMEOUT` occur in the same cycle, `acc` wins and no timeout is taken.
- **Errors:** every error clears `synced`. The committed outputs are never modified by an error or by a partial frame.
- **Reset:** clears every output, all counters, the shadow registers and the timeout counter, and sets state to HUNT_AA. This applies mid-frame as well. `clr_rdy` = 0 during and after reset until the first `acc`.

## Timing
- `clr_rdy` asserts on the edge after `acc`, for one cycle.
- Commit latency: `batt`/`curr`/`torque`/`frm_vld`/`frm_cnt`/`synced` update on the first edge after the T_LO byte is accepted, i.e. the same edge that raises `clr_rdy`.
- `err_cnt` and `synced` update on the edge after the offending `acc`, or on the edge where the timeout count is reached.
- Back-to-back bytes: minimum 2 cycles apart (the `rdy` high, then `clr_rdy` high, sequence). Nothing faster is required.

## Test plan
- **Good frame:** reset, then bytes AA 55 0F FF 01 23 07 00 → on the edge after the last accept, `batt`=0xFFF, `curr`=0x123, `torque`=0x700, one-cycle `frm_vld`, `frm_cnt`=1, `synced`=1, `err_cnt`=0. Exactly 8 `clr_rdy` pulses.
- **Garbage then resync:** bytes 12 AA AA 55 00 10 00 20 00 30 → no error from 0x12 or the repeated AA. Frame commits with `batt`=0x010, `curr`=0x020, `torque`=0x030.
- **Bad hi nibble:** AA 55 1F … → HUNT_AA, `err_cnt`=1, `synced`=0, outputs keep the previous frame values. A following good frame still commits.
- **Timeout:** AA 55 0A, then idle for `TIMEOUT`+5 cycles → `err_cnt`++, state HUNT_AA. Late remaining bytes do not commit. Repeat with the gap = `TIMEOUT`−1 → frame commits normally.
- **Reset mid-frame:** assert `rst` after 5 bytes → all outputs 0, `clr_rdy`=0. A complete frame afterwards commits with `frm_cnt`=1.
- **Saturation/wrap:** 300 bad frames → `err_cnt`=0xFF. Force `frm_cnt` to 0xFFFF, then send one good frame → `frm_cnt`=0x0000.

Source files
------------

// File: rtl/telem_frame_rx.sv
// Telemetry deframer: locks onto the 0xAA 0x55 preamble, rebuilds the 12-bit
// battery/current/torque words and keeps good-frame and framing-error counts.
module telem_frame_rx #(
   parameter int TIMEOUT = 100000,
   parameter int TO_W    = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rdy,
   output logic [11:0] batt,
   output logic [11:0] curr,
   output logic [11:0] torque,
   output logic        frm_vld,
   output logic [15:0] frm_cnt,
   output logic [7:0]  err_cnt,
   output logic        synced,
   output logic [2:0]  dbg_state
);

   // Handshake: a byte is taken when rdy is high and we did not acknowledge
   // last cycle; clr_rdy is the registered acknowledge of that accept.
   typedef enum logic [2:0] {
      HUNT_AA, HUNT_55, B_HI, B_LO, C_HI, C_LO, T_HI, T_LO
   } state_t;

   state_t          state;
   logic [11:0]     b_sh, c_sh, t_sh;
   logic [TO_W-1:0] to_cnt;
   logic            acc;
   logic            to_hit;
   logic            bad_hi;
   logic [7:0]      err_inc;

   assign acc       = rdy & ~clr_rdy;
   // An accept in the same cycle as the limit wins over the timeout.
   assign to_hit    = (state != HUNT_AA) && !acc && (to_cnt == TO_W'(TIMEOUT));
   assign bad_hi    = (rx_data[7:4] != 4'h0);
   assign err_inc   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= HUNT_AA;
         clr_rdy <= 1'b0;
         b_sh    <= '0;
         c_sh    <= '0;
         t_sh    <= '0;
         to_cnt  <= '0;
         batt    <= '0;
         curr    <= '0;
         torque  <= '0;
         frm_vld <= 1'b0;
         frm_cnt <= '0;
         err_cnt <= '0;
         synced  <= 1'b0;
      end else begin
         clr_rdy <= acc;
         frm_vld <= 1'b0;
         if (acc || state == HUNT_AA) to_cnt <= '0;
         else                         to_cnt <= to_cnt + 1'b1;

         if (to_hit) begin
            state   <= HUNT_AA;
            err_cnt <= err_inc;
            synced  <= 1'b0;
            b_sh    <= '0;
            c_sh    <= '0;
            t_sh    <= '0;
         end else if (acc) begin
            case (state)
               HUNT_AA: if (rx_data == 8'hAA) state <= HUNT_55;
               HUNT_55: begin
                  if (rx_data == 8'h55) state <= B_HI;
                  else if (rx_data != 8'hAA) begin
                     state   <= HUNT_AA;
                     err_cnt <= err_inc;
                     synced  <= 1'b0;
                  end
               end
               B_HI, C_HI, T_HI: begin
                  if (bad_hi) begin
                     state   <= HUNT_AA;
                     err_cnt <= err_inc;
                     synced  <= 1'b0;
                  end else begin
                     case (state)
                        B_HI:    begin b_sh[11:8] <= rx_data[3:0]; state <= B_LO; end
                        C_HI:    begin c_sh[11:8] <= rx_data[3:0]; state <= C_LO; end
                        default: begin t_sh[11:8] <= rx_data[3:0]; state <= T_LO; end
                     endcase
                  end
               end
               B_LO: begin b_sh[7:0] <= rx_data; state <= C_HI; end
               C_LO: begin c_sh[7:0] <= rx_data; state <= T_HI; end
               T_LO: begin
                  t_sh[7:0] <= rx_data;
                  batt      <= b_sh;
                  curr      <= c_sh;
                  torque    <= {t_sh[11:8], rx_data};
                  frm_vld   <= 1'b1;
                  frm_cnt   <= frm_cnt + 16'd1;
                  synced    <= 1'b1;
                  state     <= HUNT_AA;
               end
               default: state <= HUNT_AA;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_telem_frame_rx.sv
// Directed bench for telem_frame_rx: byte-level driver, hand-computed expected
// register values and pulse counts, one summary line.
module tb_telem_frame_rx;

   localparam int TO   = 40;
   localparam int TO_W = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [7:0]  rx_data;
   logic        clr_rdy;
   logic [11:0] batt, curr, torque;
   logic        frm_vld;
   logic [15:0] frm_cnt;
   logic [7:0]  err_cnt;
   logic        synced;
   logic [2:0]  dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   int clr_pulses = 0;
   int vld_pulses = 0;
   int clr_base, vld_base;
   logic [7:0] seq[$];

   telem_frame_rx #(.TIMEOUT(TO), .TO_W(TO_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
      .batt(batt), .curr(curr), .torque(torque), .frm_vld(frm_vld),
      .frm_cnt(frm_cnt), .err_cnt(err_cnt), .synced(synced), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (clr_rdy) clr_pulses <= clr_pulses + 1;
      if (frm_vld) vld_pulses <= vld_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; rdy stays high through the clr_rdy cycle like UART_rcv.
   task automatic send_byte(input logic [7:0] b);
      rdy = 1'b1;
      rx_data = b;
      @(negedge clk);
      @(negedge clk);
      rdy = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_seq();
      foreach (seq[i]) send_byte(seq[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      rdy = 1'b0;
      rx_data = 8'h00;
      @(negedge clk);
      do_reset();

      check("rst_batt", batt, 0);
      check("rst_frm_cnt", frm_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_synced", synced, 0);
      check("rst_clr_rdy", clr_rdy, 0);
      check("rst_state", dbg_state, 0);

      // Good frame
      clr_base = clr_pulses; vld_base = vld_pulses;
      seq = '{8'hAA, 8'h55, 8'h0F, 8'hFF, 8'h01, 8'h23, 8'h07, 8'h00};
      send_seq();
      check("good_batt", batt, 12'hFFF);
      check("good_curr", curr, 12'h123);
      check("good_torque", torque, 12'h700);
      check("good_frm_cnt", frm_cnt, 1);
      check("good_synced", synced, 1);
      check("good_err_cnt", err_cnt, 0);
      check("good_vld_pulses", vld_pulses - vld_base, 1);
      check("good_clr_pulses", clr_pulses - clr_base, 8);

      // Garbage, repeated AA, then a frame
      seq = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30};
      send_seq();
      check("resync_err_cnt", err_cnt, 0);
      check("resync_batt", batt, 12'h010);
      check("resync_curr", curr, 12'h020);
      check("resync_torque", torque, 12'h030);
      check("resync_frm_cnt", frm_cnt, 2);

      // Bad high nibble
      seq = '{8'hAA, 8'h55, 8'h1F};
      send_seq();
      check("badhi_err_cnt", err_cnt, 1);
      check("badhi_synced", synced, 0);
      check("badhi_state", dbg_state, 0);
      check("badhi_batt_kept", batt, 12'h010);
      check("badhi_torque_kept", torque, 12'h030);
      seq = '{8'hAA, 8'h55, 8'h03, 8'h45, 8'h06, 8'h78, 8'h09, 8'hAB};
      send_seq();
      check("after_bad_batt", batt, 12'h345);
      check("after_bad_curr", curr, 12'h678);
      check("after_bad_torque", torque, 12'h9AB);
      check("after_bad_frm_cnt", frm_cnt, 3);
      check("after_bad_synced", synced, 1);

      // Timeout mid-frame, then late bytes that must not commit
      seq = '{8'hAA, 8'h55, 8'h0A};
      send_seq();
      idle(TO + 5);
      check("to_err_cnt", err_cnt, 2);
      check("to_synced", synced, 0);
      check("to_state", dbg_state, 0);
      seq = '{8'h11, 8'h02, 8'h22, 8'h03, 8'h33};
      send_seq();
      check("to_late_frm_cnt", frm_cnt, 3);
      check("to_late_batt", batt, 12'h345);

      // Accept-to-accept spacing of TIMEOUT-1 cycles still commits
      seq = '{8'hAA, 8'h55, 8'h0A};
      send_seq();
      idle(TO - 4);
      seq = '{8'h11, 8'h02, 8'h22, 8'h03, 8'h33};
      send_seq();
      check("gap_frm_cnt", frm_cnt, 4);
      check("gap_batt", batt, 12'hA11);
      check("gap_curr", curr, 12'h222);
      check("gap_torque", torque, 12'h333);
      check("gap_err_cnt", err_cnt, 2);

      // Reset in the middle of a frame
      seq = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03};
      send_seq();
      do_reset();
      check("midrst_batt", batt, 0);
      check("midrst_curr", curr, 0);
      check("midrst_torque", torque, 0);
      check("midrst_frm_cnt", frm_cnt, 0);
      check("midrst_err_cnt", err_cnt, 0);
      check("midrst_clr_rdy", clr_rdy, 0);
      check("midrst_state", dbg_state, 0);
      seq = '{8'hAA, 8'h55, 8'h0B, 8'hCD, 8'h0E, 8'hF0, 8'h01, 8'h02};
      send_seq();
      check("postrst_frm_cnt", frm_cnt, 1);
      check("postrst_batt", batt, 12'hBCD);
      check("postrst_curr", curr, 12'hEF0);
      check("postrst_torque", torque, 12'h102);

      // Error counter saturation
      seq = '{8'hAA, 8'h55, 8'h1F};
      for (int k = 0; k < 300; k++) send_seq();
      check("sat_err_cnt", err_cnt, 8'hFF);
      check("sat_frm_cnt", frm_cnt, 1);

      // Frame counter wrap
      force dut.frm_cnt = 16'hFFFF;
      seq = '{8'hAA, 8'h55, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03};
      send_seq();
      release dut.frm_cnt;
      send_byte(8'h33);
      check("wrap_frm_cnt", frm_cnt, 16'h0000);
      check("wrap_batt", batt, 12'h111);
      check("wrap_synced", synced, 1);
      check("wrap_err_cnt", err_cnt, 8'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
